dphy_lp_rx_lane: RTL and testbench

Receive-side counterpart of the DSI lane transmitter. It samples the asynchronous LP line pair and decodes the line-state sequences: Stop, HS-request, Escape/LPDT entry, spaced-one-hot data bits, and Mark-1/Stop exit. It delivers LPDT bytes on a valid strobe and flags HS bursts and protocol errors. It sits on the lane's LP receive comparators, ahead of the packet decoder in the reverse/readback path.

---
 rtl/dphy_defs.sv | 33 +++
 rtl/dphy_lp_rx_lane_if.sv | 20 ++
 rtl/dphy_lp_line_filter.sv | 56 +++++
 rtl/dphy_lp_rx_lane.sv | 170 +++++++++++++++++
 tb/tb_dphy_lp_rx_lane.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/dphy_defs.sv
// rtl/dphy_defs.sv - shared LP line-state, RX FSM state and LPDT command definitions
package dphy_defs;

   typedef enum logic [1:0] {
      LP_00 = 2'b00,
      LP_01 = 2'b01,
      LP_10 = 2'b10,
      LP_11 = 2'b11
   } lp_state_t;

   typedef enum logic [3:0] {
      S_WAIT_STOP,
      S_STOP,
      S_HS_RQ,
      S_HS_ACT,
      S_ESC_RQ,
      S_ESC_BR,
      S_ESC_ACK,
      S_DATA,
      S_BIT0,
      S_BIT1,
      S_ESC_IGN
   } rx_state_t;

   localparam logic [7:0] LPDT_CMD = 8'hE1;

   function automatic logic [7:0] rev8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

endpackage

// File: rtl/dphy_lp_rx_lane_if.sv
// rtl/dphy_lp_rx_lane_if.sv - decoded LP receive outputs towards the packet decoder
interface dphy_lp_rx_lane_if;

   logic [7:0] lp_data_o;
   logic       lp_valid_o;
   logic       lp_active_o;
   logic       hs_active_o;
   logic       idle_o;
   logic       err_esc_o;
   logic       err_sync_o;

   modport master (
      output lp_data_o, lp_valid_o, lp_active_o, hs_active_o, idle_o, err_esc_o, err_sync_o
   );

   modport slave (
      input  lp_data_o, lp_valid_o, lp_active_o, hs_active_o, idle_o, err_esc_o, err_sync_o
   );

endinterface

// File: rtl/dphy_lp_line_filter.sv
// rtl/dphy_lp_line_filter.sv - optional p/n swap, 2-flop synchroniser and stability filter
module dphy_lp_line_filter
   import dphy_defs::*;
#(
   parameter bit g_invert     = 1'b0,
   parameter int g_filter_len = 2
) (
   input  logic      clk_i,
   input  logic      rst_n_i,
   input  logic      rxp_i,
   input  logic      rxn_i,
   output lp_state_t ls_o
);

   localparam logic [3:0] FL = 4'(g_filter_len);

   logic [1:0] pins;
   logic [1:0] sync1_q, sync2_q, cand_q;
   logic [3:0] cnt_q;
   lp_state_t  ls_q, ls_nxt;

   assign pins = g_invert ? {rxn_i, rxp_i} : {rxp_i, rxn_i};

   // The accepted state is exposed on the edge it is taken so the FSM reacts in the same cycle.
   always_comb begin
      ls_nxt = ls_q;
      if (sync2_q != cand_q) begin
         if (FL == 4'd1) ls_nxt = lp_state_t'(sync2_q);
      end else if (cnt_q + 4'd1 == FL) begin
         ls_nxt = lp_state_t'(cand_q);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync1_q <= 2'b00;
         sync2_q <= 2'b00;
         cand_q  <= 2'b00;
         cnt_q   <= FL;
         ls_q    <= LP_00;
      end else begin
         sync1_q <= pins;
         sync2_q <= sync1_q;
         ls_q    <= ls_nxt;
         if (sync2_q != cand_q) begin
            cand_q <= sync2_q;
            cnt_q  <= 4'd1;
         end else if (cnt_q != FL) begin
            cnt_q <= cnt_q + 4'd1;
         end
      end
   end

   assign ls_o = ls_nxt;

endmodule

// File: rtl/dphy_lp_rx_lane.sv
// rtl/dphy_lp_rx_lane.sv - LP lane receiver: Stop/HS/Escape/LPDT decode with error flags
// DPHY_LP_RX_ENTRY_CMD_EN: expect and check an LPDT entry command before data bytes.
module dphy_lp_rx_lane
   import dphy_defs::*;
#(
   parameter bit g_invert     = 1'b0,
   parameter int g_filter_len = 2,
   parameter bit g_msb_first  = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  lp_rxp_i,
   input  logic                  lp_rxn_i,
   dphy_lp_rx_lane_if.master     rx
);

   lp_state_t ls, ls_prev_q;
   rx_state_t state_q, state_nxt;
   logic [2:0] cnt_q, cnt_nxt;
   logic [7:0] sh_q, sh_nxt, data_q;
   logic       cmd_q, cmd_nxt;
   logic       valid_q, esc_q, sync_q;
   logic       esc_fail, err_esc_nxt, err_sync_nxt;
   logic       shift_en, bit_in, enter_data, byte_done, strobe;

   dphy_lp_line_filter #(
      .g_invert     (g_invert),
      .g_filter_len (g_filter_len)
   ) u_filter (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .rxp_i   (lp_rxp_i),
      .rxn_i   (lp_rxn_i),
      .ls_o    (ls)
   );

   always_comb begin
      state_nxt    = state_q;
      cnt_nxt      = cnt_q;
      sh_nxt       = sh_q;
      cmd_nxt      = cmd_q;
      esc_fail     = 1'b0;
      err_esc_nxt  = 1'b0;
      err_sync_nxt = 1'b0;
      shift_en     = 1'b0;
      bit_in       = 1'b0;
      enter_data   = 1'b0;
      byte_done    = 1'b0;
      strobe       = 1'b0;

      if (ls != ls_prev_q) begin
         case (state_q)
            S_WAIT_STOP: if (ls == LP_11) state_nxt = S_STOP;
            S_STOP: begin
               if (ls == LP_10)      state_nxt = S_ESC_RQ;
               else if (ls == LP_01) state_nxt = S_HS_RQ;
               else                  esc_fail  = 1'b1;
            end
            S_HS_RQ: begin
               if (ls == LP_00)      state_nxt = S_HS_ACT;
               else if (ls == LP_11) state_nxt = S_STOP;
               else                  esc_fail  = 1'b1;
            end
            S_HS_ACT:  if (ls == LP_11) state_nxt = S_STOP;
            S_ESC_RQ:  if (ls == LP_00) state_nxt = S_ESC_BR;  else esc_fail = 1'b1;
            S_ESC_BR:  if (ls == LP_01) state_nxt = S_ESC_ACK; else esc_fail = 1'b1;
            S_ESC_ACK: begin
               if (ls == LP_00) begin
                  state_nxt  = S_DATA;
                  enter_data = 1'b1;
               end else begin
                  esc_fail = 1'b1;
               end
            end
            S_DATA: begin
               if (ls == LP_10)      state_nxt = S_BIT1;
               else if (ls == LP_01) state_nxt = S_BIT0;
               else                  esc_fail  = 1'b1;
            end
            S_BIT0: begin
               if (ls == LP_00) begin
                  state_nxt = S_DATA;
                  shift_en  = 1'b1;
               end else begin
                  esc_fail = 1'b1;
               end
            end
            S_BIT1: begin
               if (ls == LP_00) begin
                  state_nxt = S_DATA;
                  shift_en  = 1'b1;
                  bit_in    = 1'b1;
               end else if (ls == LP_11) begin
                  state_nxt    = S_STOP;
                  err_sync_nxt = (cnt_q != 3'd0);
               end else begin
                  esc_fail = 1'b1;
               end
            end
            S_ESC_IGN: if (ls == LP_11) state_nxt = S_STOP;
            default:   state_nxt = S_WAIT_STOP;
         endcase
      end

      // Every illegal change lands in STOP when it was 11, otherwise waits for a fresh Stop.
      if (esc_fail) begin
         err_esc_nxt = 1'b1;
         state_nxt   = (ls == LP_11) ? S_STOP : S_WAIT_STOP;
      end

      if (enter_data) begin
         cnt_nxt = 3'd0;
         sh_nxt  = 8'h00;
      end

      if (shift_en) begin
         sh_nxt    = g_msb_first ? {sh_q[6:0], bit_in} : {bit_in, sh_q[7:1]};
         cnt_nxt   = cnt_q + 3'd1;
         byte_done = (cnt_q == 3'd7);
      end

`ifdef DPHY_LP_RX_ENTRY_CMD_EN
      if (enter_data) cmd_nxt = 1'b1;
      if (byte_done && cmd_q) begin
         cmd_nxt = 1'b0;
         if ((g_msb_first ? sh_nxt : rev8(sh_nxt)) != LPDT_CMD) begin
            err_esc_nxt = 1'b1;
            state_nxt   = S_ESC_IGN;
         end
      end
      strobe = byte_done && !cmd_q;
`else
      cmd_nxt = 1'b0;
      strobe  = byte_done;
`endif
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= S_WAIT_STOP;
         ls_prev_q <= LP_00;
         cnt_q     <= 3'd0;
         sh_q      <= 8'h00;
         cmd_q     <= 1'b0;
         data_q    <= 8'h00;
         valid_q   <= 1'b0;
         esc_q     <= 1'b0;
         sync_q    <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         ls_prev_q <= ls;
         cnt_q     <= cnt_nxt;
         sh_q      <= sh_nxt;
         cmd_q     <= cmd_nxt;
         valid_q   <= strobe;
         esc_q     <= err_esc_nxt;
         sync_q    <= err_sync_nxt;
         if (strobe) data_q <= sh_nxt;
      end
   end

   assign rx.lp_data_o   = data_q;
   assign rx.lp_valid_o  = valid_q;
   assign rx.lp_active_o = (state_q == S_DATA || state_q == S_BIT0 || state_q == S_BIT1) && !cmd_q;
   assign rx.hs_active_o = (state_q == S_HS_ACT);
   assign rx.idle_o      = (state_q == S_STOP);
   assign rx.err_esc_o   = esc_q;
   assign rx.err_sync_o  = sync_q;

endmodule

// File: tb/tb_dphy_lp_rx_lane.sv
// tb/tb_dphy_lp_rx_lane.sv - scoreboard bench for the LP lane receiver
module tb_dphy_lp_rx_lane;

   localparam int FL = 2;
   localparam int H  = FL + 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic rxp   = 1'b0;
   logic rxn   = 1'b0;

   int n_chk = 0, n_pass = 0;
   int n_valid = 0, n_esc = 0, n_sync = 0, hs_cyc = 0, idle_low = 0;
   int v0, e0, s0, h0, i0;
   logic [7:0] exp_q[$];

   dphy_lp_rx_lane_if rx ();

   dphy_lp_rx_lane #(
      .g_invert     (1'b0),
      .g_filter_len (FL),
      .g_msb_first  (1'b1)
   ) dut (
      .clk_i    (clk),
      .rst_n_i  (rst_n),
      .lp_rxp_i (rxp),
      .lp_rxn_i (rxn),
      .rx       (rx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (rx.lp_valid_o) begin
            n_valid++;
            check("strobe_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("lp_data", rx.lp_data_o, exp_q.pop_front());
         end
         if (rx.err_esc_o)   n_esc++;
         if (rx.err_sync_o)  n_sync++;
         if (rx.hs_active_o) hs_cyc++;
         if (!rx.idle_o)     idle_low++;
      end
   end

   // Called at a falling edge; leaves the line state applied for n cycles.
   task automatic drive(input logic [1:0] v, input int n);
      {rxp, rxn} = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      drive(b ? 2'b10 : 2'b01, H);
      drive(2'b00, H);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit push);
      if (push) exp_q.push_back(b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   task automatic entry_raw();
      drive(2'b10, H);
      drive(2'b00, H);
      drive(2'b01, H);
      drive(2'b00, H);
   endtask

   task automatic entry();
      entry_raw();
`ifdef DPHY_LP_RX_ENTRY_CMD_EN
      send_byte(8'hE1, 1'b0);
`endif
   endtask

   task automatic mark_exit();
      drive(2'b10, H);
      drive(2'b11, H);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_idle",      rx.idle_o,      0);
      check("rst_lp_active", rx.lp_active_o, 0);
      check("rst_hs_active", rx.hs_active_o, 0);
      check("rst_valid",     rx.lp_valid_o,  0);
      check("rst_data",      rx.lp_data_o,   0);
      check("rst_err_esc",   rx.err_esc_o,   0);
      check("rst_err_sync",  rx.err_sync_o,  0);

      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("wait_stop_idle", rx.idle_o, 0);
      check("wait_stop_noerr", n_esc, 0);

      {rxp, rxn} = 2'b11;
      repeat (FL + 1) @(negedge clk);
      check("stop_before_latency", rx.idle_o, 0);
      @(negedge clk);
      check("stop_at_latency", rx.idle_o, 1);
      drive(2'b11, H);

      // LPDT A5, 3C then Mark-1 exit
      v0 = n_valid; e0 = n_esc; s0 = n_sync;
      entry();
      check("lp_active_entry", rx.lp_active_o, 1);
      send_byte(8'hA5, 1'b1);
      send_byte(8'h3C, 1'b1);
      check("lp_active_data", rx.lp_active_o, 1);
      mark_exit();
      check("lpdt_strobes", n_valid - v0, 2);
      check("lpdt_active_off", rx.lp_active_o, 0);
      check("lpdt_idle", rx.idle_o, 1);
      check("lpdt_hold", rx.lp_data_o, 8'h3C);
      check("lpdt_no_esc", n_esc - e0, 0);
      check("lpdt_no_sync", n_sync - s0, 0);

      // back-to-back random bytes
      v0 = n_valid;
      entry();
      for (int k = 0; k < 3; k++) send_byte(8'($urandom_range(0, 255)), 1'b1);
      mark_exit();
      check("b2b_strobes", n_valid - v0, 3);
      check("b2b_queue_empty", exp_q.size(), 0);

      // HS burst
      v0 = n_valid; h0 = hs_cyc; e0 = n_esc;
      drive(2'b01, H);
      drive(2'b00, 100);
      drive(2'b11, H);
      check("hs_span", hs_cyc - h0, 100);
      check("hs_off", rx.hs_active_o, 0);
      check("hs_no_strobe", n_valid - v0, 0);
      check("hs_idle", rx.idle_o, 1);
      check("hs_no_esc", n_esc - e0, 0);

      // partial byte then Mark-1
      v0 = n_valid; e0 = n_esc; s0 = n_sync;
      entry();
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      mark_exit();
      check("partial_sync", n_sync - s0, 1);
      check("partial_no_strobe", n_valid - v0, 0);
      check("partial_no_esc", n_esc - e0, 0);
      check("partial_idle", rx.idle_o, 1);

      // DATA straight to 11
      e0 = n_esc; s0 = n_sync;
      entry();
      drive(2'b11, H);
      check("data_11_esc", n_esc - e0, 1);
      check("data_11_idle", rx.idle_o, 1);
      check("data_11_active", rx.lp_active_o, 0);

      // one-cycle glitch in STOP
      e0 = n_esc; i0 = idle_low;
      {rxp, rxn} = 2'b01;
      @(negedge clk);
      drive(2'b11, H);
      check("glitch_idle_kept", idle_low - i0, 0);
      check("glitch_no_esc", n_esc - e0, 0);

      // 10 directly to 01 inside DATA
      e0 = n_esc;
      entry();
      drive(2'b10, H);
      drive(2'b01, H);
      check("bit_swap_esc", n_esc - e0, 1);
      drive(2'b00, H);
      check("bit_swap_wait", rx.idle_o, 0);
      drive(2'b11, H);
      check("bit_swap_stop", rx.idle_o, 1);
      check("bit_swap_esc_once", n_esc - e0, 1);

      // reset mid-byte, then a clean byte
      entry();
      send_bit(1'b1);
      rst_n = 1'b0;
      #1;
      check("midrst_active", rx.lp_active_o, 0);
      check("midrst_data", rx.lp_data_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(2'b11, H);
      check("midrst_stop", rx.idle_o, 1);
      v0 = n_valid;
      entry();
      send_byte(8'h81, 1'b1);
      mark_exit();
      check("midrst_strobe", n_valid - v0, 1);

`ifdef DPHY_LP_RX_ENTRY_CMD_EN
      v0 = n_valid; e0 = n_esc;
      entry();
      send_byte(8'h55, 1'b1);
      mark_exit();
      check("cmd_ok_strobe", n_valid - v0, 1);
      check("cmd_ok_no_esc", n_esc - e0, 0);

      v0 = n_valid; e0 = n_esc;
      entry_raw();
      check("cmd_phase_inactive", rx.lp_active_o, 0);
      send_byte(8'h1E, 1'b0);
      check("cmd_bad_esc", n_esc - e0, 1);
      send_bit(1'b1);
      check("cmd_bad_inactive", rx.lp_active_o, 0);
      mark_exit();
      check("cmd_bad_no_strobe", n_valid - v0, 0);
      check("cmd_bad_esc_once", n_esc - e0, 1);
      check("cmd_bad_idle", rx.idle_o, 1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
